// File: rtl/axi_rd_arbiter.sv
// Round-robin arbiter sharing one AXI4 read port among NUM_MASTERS requesters.
// Optional urgent-priority tier is enabled with AXI_RD_ARB_URGENT_EN.
module axi_rd_arbiter #(
   parameter int NUM_MASTERS     = 4,
   parameter int ADDR_WIDTH      = 32,
   parameter int DATA_WIDTH      = 64,
   parameter int ID_WIDTH        = 4,
   parameter int MAX_OUTSTANDING = 8,
   localparam int MW = $clog2(NUM_MASTERS),
   localparam int CW = $clog2(MAX_OUTSTANDING + 1)
) (
   input  logic                             clk_i,
   input  logic                             rst_i,
   input  logic [NUM_MASTERS-1:0]           s_arvalid_i,
   output logic [NUM_MASTERS-1:0]           s_arready_o,
   input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] s_araddr_i,
   input  logic [NUM_MASTERS*ID_WIDTH-1:0]  s_arid_i,
   input  logic [NUM_MASTERS*8-1:0]         s_arlen_i,
`ifdef AXI_RD_ARB_URGENT_EN
   input  logic [NUM_MASTERS-1:0]           s_urgent_i,
`endif
   output logic [NUM_MASTERS-1:0]           s_rvalid_o,
   input  logic [NUM_MASTERS-1:0]           s_rready_i,
   output logic [DATA_WIDTH-1:0]            s_rdata_o,
   output logic [ID_WIDTH-1:0]              s_rid_o,
   output logic [1:0]                       s_rresp_o,
   output logic                             s_rlast_o,
   output logic                             m_arvalid_o,
   input  logic                             m_arready_i,
   output logic [ADDR_WIDTH-1:0]            m_araddr_o,
   output logic [ID_WIDTH+MW-1:0]           m_arid_o,
   output logic [7:0]                       m_arlen_o,
   input  logic                             m_rvalid_i,
   output logic                             m_rready_o,
   input  logic [DATA_WIDTH-1:0]            m_rdata_i,
   input  logic [ID_WIDTH+MW-1:0]           m_rid_i,
   input  logic [1:0]                       m_rresp_i,
   input  logic                             m_rlast_i,
   output logic                             err_o
);

   typedef enum logic {
      IDLE,
      GRANT
   } state_t;

   state_t state_q, state_d;

   logic [MW-1:0] grant_q, grant_d;
   logic [MW-1:0] rr_q, rr_d;
   logic [MW-1:0] pick, cand;
   logic [MW-1:0] r_idx;
   logic [CW-1:0] cnt_q [NUM_MASTERS];

   logic [NUM_MASTERS-1:0] eligible;
   logic [NUM_MASTERS-1:0] req_mask;
   logic [NUM_MASTERS-1:0] ar_inc;
   logic [NUM_MASTERS-1:0] r_dec;

   logic found;
   logic ar_hs;
   logic r_ok;
   logic r_hs_last;
   logic dec_at_zero;
   logic err_set;
   logic err_q;

   always_comb begin
      eligible = '0;
      for (int k = 0; k < NUM_MASTERS; k++) begin
         eligible[k] = s_arvalid_i[k] &&
                       (cnt_q[k] < CW'(MAX_OUTSTANDING));
      end
   end

`ifdef AXI_RD_ARB_URGENT_EN
   logic [NUM_MASTERS-1:0] urgent_elig;

   // Urgent requesters shadow everyone else while any is eligible.
   assign urgent_elig = eligible & s_urgent_i;
   assign req_mask    = (|urgent_elig) ? urgent_elig : eligible;
`else
   assign req_mask = eligible;
`endif

   // First requester after the last winner, wrapping.
   always_comb begin
      pick  = '0;
      cand  = '0;
      found = 1'b0;
      for (int i = 1; i <= NUM_MASTERS; i++) begin
         cand = MW'((int'(rr_q) + i) % NUM_MASTERS);
         if (!found && req_mask[cand]) begin
            found = 1'b1;
            pick  = cand;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         grant_q <= '0;
         rr_q    <= MW'(NUM_MASTERS - 1);
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         rr_q    <= rr_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      rr_d        = rr_q;
      m_arvalid_o = 1'b0;
      s_arready_o = '0;
      ar_hs       = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (found) begin
               grant_d = pick;
               state_d = GRANT;
            end
         end
         GRANT: begin
            m_arvalid_o          = s_arvalid_i[grant_q];
            s_arready_o[grant_q] = m_arready_i;
            if (m_arvalid_o && m_arready_i) begin
               ar_hs   = 1'b1;
               rr_d    = grant_q;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign m_araddr_o = s_araddr_i[int'(grant_q)*ADDR_WIDTH +: ADDR_WIDTH];
   assign m_arlen_o  = s_arlen_i[int'(grant_q)*8 +: 8];
   assign m_arid_o   = {grant_q, s_arid_i[int'(grant_q)*ID_WIDTH +: ID_WIDTH]};

   assign r_idx = m_rid_i[ID_WIDTH +: MW];
   assign r_ok  = (int'(r_idx) < NUM_MASTERS);

   // Beats for a nonexistent master are swallowed so the channel never stalls.
   always_comb begin
      s_rvalid_o = '0;
      m_rready_o = 1'b1;
      if (r_ok) begin
         s_rvalid_o[r_idx] = m_rvalid_i;
         m_rready_o        = s_rready_i[r_idx];
      end
   end

   assign s_rdata_o = m_rdata_i;
   assign s_rid_o   = m_rid_i[ID_WIDTH-1:0];
   assign s_rresp_o = m_rresp_i;
   assign s_rlast_o = m_rlast_i;

   assign r_hs_last = m_rvalid_i && m_rready_o && m_rlast_i;

   always_comb begin
      ar_inc      = '0;
      r_dec       = '0;
      dec_at_zero = 1'b0;
      for (int k = 0; k < NUM_MASTERS; k++) begin
         ar_inc[k] = ar_hs && (grant_q == MW'(k));
         r_dec[k]  = r_hs_last && r_ok && (r_idx == MW'(k));
         if (r_dec[k] && (cnt_q[k] == '0)) begin
            dec_at_zero = 1'b1;
         end
      end
   end

   assign err_set = (m_rvalid_i && !r_ok) || dec_at_zero;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int k = 0; k < NUM_MASTERS; k++) begin
            cnt_q[k] <= '0;
         end
      end else begin
         for (int k = 0; k < NUM_MASTERS; k++) begin
            unique case ({ar_inc[k], r_dec[k]})
               2'b10: cnt_q[k] <= cnt_q[k] + 1'b1;
               2'b01: begin
                  if (cnt_q[k] != '0) begin
                     cnt_q[k] <= cnt_q[k] - 1'b1;
                  end
               end
               default: cnt_q[k] <= cnt_q[k];
            endcase
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         err_q <= 1'b0;
      end else if (err_set) begin
         err_q <= 1'b1;
      end
   end

   assign err_o = err_q;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed scoreboard bench for axi_rd_arbiter.
// Build with AXI_RD_ARB_URGENT_EN defined to exercise the urgent tier.
module tb_axi_rd_arbiter;

   logic clk = 1'b0;
   logic rst;

   logic [3:0]   s_arvalid, s_arready, s_rvalid, s_rready;
   logic [127:0] s_araddr;
   logic [15:0]  s_arid;
   logic [31:0]  s_arlen;
   logic [63:0]  s_rdata;
   logic [3:0]   s_rid;
   logic [1:0]   s_rresp;
   logic         s_rlast;
`ifdef AXI_RD_ARB_URGENT_EN
   logic [3:0]   s_urgent;
`endif
   logic         m_arvalid, m_arready;
   logic [31:0]  m_araddr;
   logic [5:0]   m_arid;
   logic [7:0]   m_arlen;
   logic         m_rvalid, m_rready;
   logic [63:0]  m_rdata;
   logic [5:0]   m_rid;
   logic [1:0]   m_rresp;
   logic         m_rlast;
   logic         err;

   int checks   = 0;
   int failures = 0;
   int waited;
   logic [63:0] sb_q [$];
   logic [63:0] exp_v;

   always #5 clk = ~clk;

   axi_rd_arbiter dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .s_arvalid_i (s_arvalid),
      .s_arready_o (s_arready),
      .s_araddr_i  (s_araddr),
      .s_arid_i    (s_arid),
      .s_arlen_i   (s_arlen),
`ifdef AXI_RD_ARB_URGENT_EN
      .s_urgent_i  (s_urgent),
`endif
      .s_rvalid_o  (s_rvalid),
      .s_rready_i  (s_rready),
      .s_rdata_o   (s_rdata),
      .s_rid_o     (s_rid),
      .s_rresp_o   (s_rresp),
      .s_rlast_o   (s_rlast),
      .m_arvalid_o (m_arvalid),
      .m_arready_i (m_arready),
      .m_araddr_o  (m_araddr),
      .m_arid_o    (m_arid),
      .m_arlen_o   (m_arlen),
      .m_rvalid_i  (m_rvalid),
      .m_rready_o  (m_rready),
      .m_rdata_i   (m_rdata),
      .m_rid_i     (m_rid),
      .m_rresp_i   (m_rresp),
      .m_rlast_i   (m_rlast),
      .err_o       (err)
   );

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [63:0] exp_ar(input int k, input logic [3:0] id);
      logic [1:0] kk;
      kk = 2'(k);
      return {18'b0, 8'(k + 3), 32'(32'h1000 * (k + 1)), kk, id};
   endfunction

   task automatic set_ar(input int k, input logic v, input logic [3:0] id);
      s_arvalid[k]       = v;
      s_arid[k*4 +: 4]   = id;
   endtask

   task automatic expect_ar(input string tag, output int w);
      logic [63:0] e;
      bit got;
      got = 1'b0;
      w   = 0;
      for (int n = 0; n < 20 && !got; n++) begin
         if (m_arvalid && m_arready) got = 1'b1;
         else begin
            tick();
            w++;
         end
      end
      e = '1;
      if (sb_q.size() > 0) e = sb_q.pop_front();
      chk({tag, "_seen"}, 64'(got), 64'd1);
      if (got) begin
         chk(tag, 64'({m_arlen, m_araddr, m_arid}), e);
         tick();
      end
   endtask

   task automatic stall_check(input string tag, input int cycles);
      int seen;
      seen = 0;
      for (int n = 0; n < cycles; n++) begin
         if (m_arvalid || (s_arready != 4'b0)) seen++;
         tick();
      end
      chk(tag, 64'(seen), 64'd0);
   endtask

   task automatic r_drive(input logic [5:0] rid, input logic last,
                          input logic [3:0] rdy);
      m_rvalid = 1'b1;
      m_rid    = rid;
      m_rlast  = last;
      s_rready = rdy;
      #1;
   endtask

   task automatic r_idle();
      m_rvalid = 1'b0;
      m_rlast  = 1'b0;
      s_rready = 4'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst       = 1'b1;
      s_arvalid = '0;
      s_arid    = '0;
      s_rready  = '0;
      m_arready = 1'b1;
      m_rvalid  = 1'b0;
      m_rdata   = '0;
      m_rid     = '0;
      m_rresp   = '0;
      m_rlast   = 1'b0;
`ifdef AXI_RD_ARB_URGENT_EN
      s_urgent  = '0;
`endif
      for (int k = 0; k < 4; k++) begin
         s_araddr[k*32 +: 32] = 32'(32'h1000 * (k + 1));
         s_arlen[k*8 +: 8]    = 8'(k + 3);
      end
      tick();
      tick();
      rst = 1'b0;

      chk("rst_arvalid", 64'(m_arvalid), 64'd0);
      chk("rst_arready", 64'(s_arready), 64'd0);
      chk("rst_err", 64'(err), 64'd0);

      // round robin over all four
      for (int k = 0; k < 4; k++) set_ar(k, 1'b1, 4'(k + 1));
      for (int g = 0; g < 5; g++) begin
         sb_q.push_back(exp_ar(g % 4, 4'((g % 4) + 1)));
         expect_ar($sformatf("rr_grant%0d", g), waited);
         chk($sformatf("rr_lat%0d", g), 64'(waited), 64'd1);
         chk($sformatf("rr_gap%0d", g), 64'(m_arvalid), 64'd0);
      end
      s_arvalid = '0;

      // id prefix and R routing
      set_ar(2, 1'b1, 4'h5);
      sb_q.push_back(exp_ar(2, 4'h5));
      expect_ar("id_prefix", waited);
      s_arvalid = '0;
      m_rdata = 64'hDEAD_BEEF_0123_4567;
      m_rresp = 2'b10;
      r_drive(6'h25, 1'b0, 4'b1111);
      chk("r_route", 64'(s_rvalid), 64'b0100);
      chk("r_id_strip", 64'(s_rid), 64'h5);
      chk("r_rready", 64'(m_rready), 64'd1);
      chk("r_rdata", s_rdata, 64'hDEAD_BEEF_0123_4567);
      chk("r_rresp", 64'(s_rresp), 64'd2);
      s_rready = 4'b1011;
      #1;
      chk("r_rready_sel", 64'(m_rready), 64'd0);
      tick();
      r_idle();

      // outstanding cap on master 1
      r_drive(6'h10, 1'b1, 4'b0010);
      tick();
      r_idle();
      set_ar(1, 1'b1, 4'h7);
      for (int g = 0; g < 8; g++) begin
         sb_q.push_back(exp_ar(1, 4'h7));
         expect_ar($sformatf("cap_ar%0d", g), waited);
      end
      stall_check("cap_stall", 5);
      set_ar(0, 1'b1, 4'hA);
      sb_q.push_back(exp_ar(0, 4'hA));
      expect_ar("cap_other", waited);
      s_arvalid[0] = 1'b0;
      r_drive(6'h10, 1'b1, 4'b0010);
      tick();
      r_idle();
      sb_q.push_back(exp_ar(1, 4'h7));
      expect_ar("cap_release", waited);
      s_arvalid = '0;

      // same-cycle inc and dec on master 0 at count 3
      set_ar(0, 1'b1, 4'hB);
      sb_q.push_back(exp_ar(0, 4'hB));
      tick();
      exp_v = sb_q.pop_front();
      chk("same_ar", 64'({m_arlen, m_araddr, m_arid}), exp_v);
      r_drive(6'h00, 1'b1, 4'b0001);
      chk("same_rready", 64'(m_rready), 64'd1);
      tick();
      r_idle();
      for (int g = 0; g < 5; g++) begin
         sb_q.push_back(exp_ar(0, 4'hB));
         expect_ar($sformatf("same_fill%0d", g), waited);
      end
      stall_check("same_stall", 4);
      s_arvalid = '0;

      // decrement at zero sets sticky error
      r_drive(6'h39, 1'b1, 4'b1000);
      chk("z_route", 64'(s_rvalid), 64'b1000);
      tick();
      r_idle();
      chk("z_err_ok", 64'(err), 64'd0);
      r_drive(6'h39, 1'b1, 4'b1000);
      chk("z_rready", 64'(m_rready), 64'd1);
      tick();
      r_idle();
      chk("z_err_set", 64'(err), 64'd1);
      tick();
      tick();
      chk("z_err_sticky", 64'(err), 64'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("z_err_clr", 64'(err), 64'd0);

      // counters and pointer restart after reset
      set_ar(1, 1'b1, 4'h3);
      set_ar(0, 1'b1, 4'h2);
      sb_q.push_back(exp_ar(0, 4'h2));
      sb_q.push_back(exp_ar(1, 4'h3));
      expect_ar("post_rst0", waited);
      expect_ar("post_rst1", waited);
      s_arvalid = '0;

`ifdef AXI_RD_ARB_URGENT_EN
      tick();
      s_urgent = 4'b1000;
      set_ar(0, 1'b1, 4'h1);
      set_ar(3, 1'b1, 4'h4);
      sb_q.push_back(exp_ar(3, 4'h4));
      sb_q.push_back(exp_ar(0, 4'h1));
      expect_ar("urg_first", waited);
      s_arvalid[3] = 1'b0;
      expect_ar("urg_second", waited);
      s_arvalid = '0;
      s_urgent  = '0;
`endif

      chk("sb_drain", 64'(sb_q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
